// File: rtl/wb_prefetch_buf_pkg.sv
// Shared Wishbone constants and the prefetch buffer state encoding.
package wb_common_params;

  // Wishbone registered-feedback cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC      = 3'b000;
  localparam logic [2:0] CTI_INC_BURST    = 3'b010;
  localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

  // Burst type: only linear bursts are ever issued
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  // HIT_ACK doubles as the one-cycle response state after FILL and PASS
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIT_ACK = 2'd1,
    FILL    = 2'd2,
    PASS    = 2'd3
  } state_t;

endpackage

// File: rtl/wb_prefetch_line.sv
// Line storage: one write port, asynchronous read mux.
module wb_prefetch_line #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wr_idx,
  input  logic [31:0]                   i_wr_dat,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rd_idx,
  output logic [31:0]                   o_rd_dat
);

  localparam int IW = $clog2(LINE_WORDS);

  logic [31:0] r_mem [LINE_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      // Each word captures the fill data when its index is written
      always_ff @(posedge clk) begin
        if (i_we && (i_wr_idx == IW'(gi))) begin
          r_mem[gi] <= i_wr_dat;
        end
      end
    end
  endgenerate

  assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/wb_prefetch_buf.sv
// Single-line read-prefetch buffer between the CPU Wishbone port and the intercon.
module wb_prefetch_buf
  import wb_common_params::*;
#(
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] CACHE_BASE = 32'h0000_0000,
  parameter logic [31:0] CACHE_MASK = 32'hF000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        flush_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int LB = IW + 2;
  localparam int TW = 32 - LB;

  state_t        r_state;
  logic          r_valid;
  logic [TW-1:0] r_tag;
  logic [IW-1:0] r_fill_cnt;
  logic [IW-1:0] r_idx;
  logic          r_flush_pend;
  logic          r_cpu_gone;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_dat;
  logic [31:0]   r_m_adr;
  logic [31:0]   r_m_dat;
  logic [3:0]    r_m_sel;
  logic          r_m_we;
  logic          r_m_cyc;
  logic [2:0]    r_m_cti;

  logic          w_req;
  logic          w_cacheable;
  logic          w_hit;
  logic          w_last;
  logic          w_cpu_here;
  logic          w_line_we;
  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_next_cnt;
  logic [31:0]   w_line_rd;

  // The ack/err terms stop a second accept during the response cycle
  assign w_req       = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;
  assign w_cacheable = (wbs_adr_i & CACHE_MASK) == CACHE_BASE;
  assign w_hit       = ~wbs_we_i & w_cacheable & r_valid & (wbs_adr_i[31:LB] == r_tag);
  assign w_last      = r_fill_cnt == IW'(LINE_WORDS - 1);
  assign w_next_cnt  = r_fill_cnt + IW'(1);
  // A CPU that dropped cyc at any point during the transfer gets no response
  assign w_cpu_here  = wbs_cyc_i & ~r_cpu_gone;
  assign w_line_we   = (r_state == FILL) & wbm_ack_i & ~wbm_err_i;
  assign w_rd_idx    = (r_state == IDLE) ? wbs_adr_i[LB-1:2] : r_idx;

  wb_prefetch_line #(.LINE_WORDS(LINE_WORDS)) u_line (
    .clk      (wb_clk_i),
    .i_we     (w_line_we),
    .i_wr_idx (r_fill_cnt),
    .i_wr_dat (wbm_dat_i),
    .i_rd_idx (w_rd_idx),
    .o_rd_dat (w_line_rd)
  );

  // Control FSM with all bus outputs registered
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_tag        <= '0;
      r_fill_cnt   <= '0;
      r_idx        <= '0;
      r_flush_pend <= 1'b0;
      r_cpu_gone   <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_dat        <= '0;
      r_m_adr      <= '0;
      r_m_dat      <= '0;
      r_m_sel      <= '0;
      r_m_we       <= 1'b0;
      r_m_cyc      <= 1'b0;
      r_m_cti      <= CTI_CLASSIC;
    end else begin
      case (r_state)
        IDLE: begin
          r_cpu_gone   <= 1'b0;
          r_flush_pend <= 1'b0;
          if (flush_i) r_valid <= 1'b0;
          if (w_req) begin
            r_idx <= wbs_adr_i[LB-1:2];
            if (w_hit) begin
              r_ack   <= 1'b1;
              r_dat   <= w_line_rd;
              r_state <= HIT_ACK;
            end else if (!wbs_we_i && w_cacheable) begin
              r_m_adr    <= {wbs_adr_i[31:LB], {LB{1'b0}}};
              r_m_sel    <= 4'hF;
              r_m_we     <= 1'b0;
              r_m_cyc    <= 1'b1;
              r_m_cti    <= CTI_INC_BURST;
              r_fill_cnt <= '0;
              r_state    <= FILL;
            end else begin
              r_m_adr <= wbs_adr_i;
              r_m_dat <= wbs_dat_i;
              r_m_sel <= wbs_sel_i;
              r_m_we  <= wbs_we_i;
              r_m_cyc <= 1'b1;
              r_m_cti <= CTI_CLASSIC;
              r_state <= PASS;
            end
          end
        end
        HIT_ACK: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          if (flush_i) r_valid <= 1'b0;
          r_state <= IDLE;
        end
        FILL: begin
          if (!wbs_cyc_i) r_cpu_gone <= 1'b1;
          if (flush_i) r_flush_pend <= 1'b1;
          if (wbm_err_i) begin
            r_m_cyc    <= 1'b0;
            r_m_cti    <= CTI_CLASSIC;
            r_valid    <= 1'b0;
            r_fill_cnt <= '0;
            r_err      <= w_cpu_here;
            r_state    <= HIT_ACK;
          end else if (wbm_ack_i) begin
            if (w_last) begin
              r_m_cyc    <= 1'b0;
              r_m_cti    <= CTI_CLASSIC;
              r_fill_cnt <= '0;
              r_valid    <= ~(r_flush_pend | flush_i);
              r_tag      <= r_m_adr[31:LB];
              r_ack      <= w_cpu_here;
              // The requested word is either this beat or already stored
              r_dat      <= (r_idx == r_fill_cnt) ? wbm_dat_i : w_line_rd;
              r_state    <= HIT_ACK;
            end else begin
              r_fill_cnt <= w_next_cnt;
              r_m_adr    <= r_m_adr + 32'd4;
              r_m_cti    <= (w_next_cnt == IW'(LINE_WORDS - 1)) ? CTI_END_OF_BURST
                                                                 : CTI_INC_BURST;
            end
          end
        end
        PASS: begin
          if (!wbs_cyc_i) r_cpu_gone <= 1'b1;
          if (flush_i) r_valid <= 1'b0;
          if (wbm_ack_i || wbm_err_i) begin
            r_m_cyc <= 1'b0;
            r_ack   <= wbm_ack_i & ~wbm_err_i & w_cpu_here;
            r_err   <= wbm_err_i & w_cpu_here;
            r_dat   <= wbm_dat_i;
            // No write-through: a write into the buffered line just invalidates it
            if (r_m_we && (r_m_adr[31:LB] == r_tag)) r_valid <= 1'b0;
            r_state <= HIT_ACK;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wbs_dat_o = r_dat;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbm_adr_o = r_m_adr;
  assign wbm_dat_o = r_m_dat;
  assign wbm_sel_o = r_m_sel;
  assign wbm_we_o  = r_m_we;
  assign wbm_cyc_o = r_m_cyc;
  assign wbm_stb_o = r_m_cyc;
  assign wbm_cti_o = r_m_cti;
  assign wbm_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_wb_prefetch_buf.sv
// Self-checking bench for wb_prefetch_buf: vector table plus corner-case sequences.
module tb_wb_prefetch_buf;

  localparam int LINE_WORDS = 4;
  localparam int K_HIT  = 0;
  localparam int K_FILL = 1;
  localparam int K_PASS = 2;

  logic        clk = 1'b0;
  logic        wb_rst_i, flush_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  always #5 clk = ~clk;

  wb_prefetch_buf #(.LINE_WORDS(LINE_WORDS)) dut (
    .wb_clk_i (clk),       .wb_rst_i (wb_rst_i),   .flush_i  (flush_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),  .wbs_sel_i(wbs_sel_i),
    .wbs_we_i (wbs_we_i),  .wbs_cyc_i(wbs_cyc_i),  .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),  .wbs_err_o(wbs_err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),  .wbm_sel_o(wbm_sel_o),
    .wbm_we_o (wbm_we_o),  .wbm_cyc_o(wbm_cyc_o),  .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),  .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  typedef struct { logic err; logic [31:0] dat; } resp_t;
  typedef struct { logic [31:0] adr; logic [2:0] cti; logic we; logic [3:0] sel; logic [31:0] dat; } beat_t;
  typedef struct { logic [31:0] adr; logic we; logic [31:0] wd; int kind; logic [31:0] exp_d; } vec_t;

  resp_t exp_resp[$];
  beat_t exp_beat[$];
  vec_t  vecs[11];

  int total = 0;
  int bad   = 0;
  int slave_wait = 0;
  int err_beat   = 0;
  bit sb_on      = 1'b1;
  int beat, wcnt;
  logic [3:0] gen = 4'd0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endfunction

  // Slave memory contents: generation nibble, address-derived middle, A0+word low byte
  function automatic logic [31:0] slave_data(input logic [31:0] a, input logic [3:0] g);
    logic [31:0] x;
    x = a ^ 32'h100;
    return {g, x[23:4], 8'hA0 + {6'b0, a[3:2]}};
  endfunction

  // Intercon slave model with wait states, error injection and beat scoreboard
  initial begin
    wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = 0; beat = 0; wcnt = 0;
    forever begin
      @(negedge clk);
      wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = 0;
      if (wb_rst_i || !(wbm_cyc_o && wbm_stb_o)) begin
        beat = 0; wcnt = 0;
      end else if (wcnt < slave_wait) begin
        wcnt++;
      end else begin
        beat_t b;
        wcnt = 0;
        beat++;
        if (sb_on) begin
          if (exp_beat.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got adr %h expected no beat", wbm_adr_o);
          end else begin
            b = exp_beat.pop_front();
            chk("beat_adr", wbm_adr_o, b.adr);
            chk("beat_cti", {29'b0, wbm_cti_o}, {29'b0, b.cti});
            chk("beat_bte", {30'b0, wbm_bte_o}, 32'h0);
            chk("beat_we_sel", {27'b0, wbm_we_o, wbm_sel_o}, {27'b0, b.we, b.sel});
            if (b.we) chk("beat_wdat", wbm_dat_o, b.dat);
          end
        end
        if (beat == err_beat) wbm_err_i = 1;
        else begin
          wbm_ack_i = 1;
          if (wbm_we_o) gen = gen + 4'd1;
          else wbm_dat_i = slave_data(wbm_adr_o, gen);
        end
      end
    end
  end

  // CPU-side response monitor: pops the expected response on every ack/err
  initial begin
    forever begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", {30'b0, wbs_ack_o, wbs_err_o}, 32'h0);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          chk("resp_err", {31'b0, wbs_err_o}, {31'b0, r.err});
          chk("resp_ack", {31'b0, wbs_ack_o}, {31'b0, ~r.err});
          if (!r.err) chk("resp_dat", wbs_dat_o, r.dat);
          $display("resp: ack=%0b err=%0b dat=%h", wbs_ack_o, wbs_err_o, wbs_dat_o);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_sdat"}, wbs_dat_o, 0);
    chk({tag, "_sack_err"}, {30'b0, wbs_ack_o, wbs_err_o}, 0);
    chk({tag, "_madr"}, wbm_adr_o, 0);
    chk({tag, "_mdat"}, wbm_dat_o, 0);
    chk({tag, "_mctl"}, {17'b0, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o}, 0);
  endtask

  // One CPU access: push expectations, drive the request, wait (bounded) for the response
  task automatic cpu_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                            input int kind, input logic [31:0] exp_d, input logic exp_e,
                            input int nbeats, input int flush_at);
    int cyc_n;
    logic seen_m;
    logic [31:0] base;
    resp_t r;
    beat_t b;
    r.err = exp_e; r.dat = exp_d;
    exp_resp.push_back(r);
    base = adr & ~32'(LINE_WORDS * 4 - 1);
    if (kind == K_FILL) begin
      for (int i = 0; i < nbeats; i++) begin
        b.adr = base + 32'(4 * i);
        b.cti = (i == LINE_WORDS - 1) ? 3'b111 : 3'b010;
        b.we = 1'b0; b.sel = 4'hF; b.dat = 0;
        exp_beat.push_back(b);
      end
    end else if (kind == K_PASS) begin
      b.adr = adr; b.cti = 3'b000; b.we = we; b.sel = 4'hF; b.dat = wd;
      exp_beat.push_back(b);
    end
    @(negedge clk);
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wd; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    cyc_n = 0; seen_m = 0;
    while (!(wbs_ack_o || wbs_err_o) && cyc_n < 200) begin
      @(negedge clk);
      cyc_n++;
      if (wbm_cyc_o) seen_m = 1;
      flush_i = (cyc_n == flush_at);
    end
    flush_i = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    $display("access adr=%h we=%0b kind=%0d cycles=%0d", adr, we, kind, cyc_n);
    chk("response_seen", {31'b0, wbs_ack_o | wbs_err_o}, 1);
    chk("master_idle_at_resp", {31'b0, wbm_cyc_o}, 0);
    if (kind == K_HIT) begin
      chk("hit_latency", 32'(cyc_n), 1);
      chk("hit_no_master", {31'b0, seen_m}, 0);
    end
    @(negedge clk);
    chk("resp_pulse_width", {30'b0, wbs_ack_o, wbs_err_o}, 0);
    chk("beats_left", 32'(exp_beat.size()), 0);
    exp_beat.delete();
    exp_resp.delete();
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0104, 1'b0, 32'h0,  K_FILL, 32'h0000_00A1};
    vecs[1]  = '{32'h0000_0108, 1'b0, 32'h0,  K_HIT,  32'h0000_00A2};
    vecs[2]  = '{32'h0000_010C, 1'b0, 32'h0,  K_HIT,  32'h0000_00A3};
    vecs[3]  = '{32'h0000_0100, 1'b1, 32'h55, K_PASS, 32'h0000_0000};
    vecs[4]  = '{32'h0000_0100, 1'b0, 32'h0,  K_FILL, 32'h1000_00A0};
    vecs[5]  = '{32'h2000_0000, 1'b0, 32'h0,  K_PASS, 32'h1000_10A0};
    vecs[6]  = '{32'h0000_0104, 1'b0, 32'h0,  K_HIT,  32'h1000_00A1};
    vecs[7]  = '{32'h0000_1008, 1'b0, 32'h0,  K_FILL, 32'h1001_10A2};
    vecs[8]  = '{32'h0000_0100, 1'b0, 32'h0,  K_FILL, 32'h1000_00A0};
    vecs[9]  = '{32'h2000_0004, 1'b1, 32'h77, K_PASS, 32'h0000_0000};
    vecs[10] = '{32'h0000_010C, 1'b0, 32'h0,  K_HIT,  32'h1000_00A3};

    wb_rst_i = 1; flush_i = 0; wbs_adr_i = 0; wbs_dat_i = 0; wbs_sel_i = 0;
    wbs_we_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    wb_rst_i = 0;

    for (int i = 0; i < 11; i++) begin
      cpu_access(vecs[i].adr, vecs[i].we, vecs[i].wd, vecs[i].kind, vecs[i].exp_d, 1'b0,
                 (vecs[i].kind == K_FILL) ? LINE_WORDS : ((vecs[i].kind == K_PASS) ? 1 : 0), -1);
    end

    // Error on the third fill beat, then the same line refetches and hits
    err_beat = 3;
    cpu_access(32'h0000_2004, 1'b0, 0, K_FILL, 32'h0, 1'b1, 3, -1);
    err_beat = 0;
    cpu_access(32'h0000_2004, 1'b0, 0, K_FILL, 32'h2002_10A1, 1'b0, LINE_WORDS, -1);
    cpu_access(32'h0000_2008, 1'b0, 0, K_HIT,  32'h2002_10A2, 1'b0, 0, -1);

    // Flush in the middle of a slow fill: word returned, line left invalid
    slave_wait = 2;
    cpu_access(32'h0000_3008, 1'b0, 0, K_FILL, 32'h2003_10A2, 1'b0, LINE_WORDS, 3);
    slave_wait = 0;
    cpu_access(32'h0000_300C, 1'b0, 0, K_FILL, 32'h2003_10A3, 1'b0, LINE_WORDS, -1);
    cpu_access(32'h0000_3000, 1'b0, 0, K_HIT,  32'h2003_10A0, 1'b0, 0, -1);

    // Reset in the middle of a burst
    sb_on = 0; slave_wait = 2;
    @(negedge clk);
    wbs_adr_i = 32'h0000_4000; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_cyc_i = 1; wbs_stb_i = 1;
    repeat (3) @(negedge clk);
    chk("mid_burst_cyc", {31'b0, wbm_cyc_o}, 1);
    wb_rst_i = 1;
    @(negedge clk);
    wb_rst_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    check_all_zero("mid_reset");
    $display("reset mid-burst applied");
    @(negedge clk);
    sb_on = 1; slave_wait = 0;
    cpu_access(32'h0000_0104, 1'b0, 0, K_FILL, 32'h2000_00A1, 1'b0, LINE_WORDS, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_prefetch_buf.md
Name: wb_prefetch_buf

Overview:
- Single-line read-prefetch buffer between the picorv32_wb master port and the Wishbone intercon master slot. It sits downstream of the CPU and upstream of the intercon.
- A read miss in the cacheable region fetches one aligned line with a linear incrementing burst. Later reads that hit the line are answered locally in 1 cycle.
- Reads outside the region, and all writes, pass through as single classic cycles.
- Its purpose is to cut instruction-fetch latency from slow slaves (SDRAM, SPI flash).

Parameters:
- LINE_WORDS, 4, words per line; power of 2, range 2..16.
- CACHE_BASE, 32'h0000_0000, base of the cacheable region.
- CACHE_MASK, 32'hF000_0000, region compare mask. A read is cacheable iff (adr & CACHE_MASK) == CACHE_BASE.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset: one clock; synchronous, active-high.
- flush_i  in  1  invalidate line (pulse).
- wbs_adr_i  in  32  slave address from CPU.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte selects.
- wbs_we_i  in  1  write enable.
- wbs_cyc_i  in  1  cycle.
- wbs_stb_i  in  1  strobe.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  acknowledge.
- wbs_err_o  out  1  error.
- wbm_adr_o  out  32  master address to intercon.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte selects.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type.
- wbm_bte_o  out  2  burst type; always 2'b00 (linear).
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  error.

Behaviour:
- All outputs are registered. On reset:
  - every output is 0;
  - valid=0, state=IDLE, fill_cnt=0.
- Reset asserted mid-burst drops wbm_cyc_o/wbm_stb_o at that edge, with no slave ack.
- Line geometry:
  - LB = log2(LINE_WORDS) + 2.
  - tag = adr[31:LB]; word index = adr[LB-1:2].
- IDLE accepts a request only when wbs_cyc_i & wbs_stb_i & !wbs_ack_o & !wbs_err_o. This prevents a double accept in the ack cycle.
- Hit (read, cacheable, valid, tag match) -> HIT_ACK:
  - wbs_ack_o=1 for exactly 1 cycle;
  - wbs_dat_o = line[index];
  - latency is 1 cycle from the accept edge.
- Miss (read, cacheable, not hit) -> FILL:
  - master drives adr = {tag, LB'b0}, sel=4'hF, we=0, cti=3'b010;
  - each wbm_ack_i stores wbm_dat_i into line[fill_cnt], increments fill_cnt and adr by 4;
  - cti=3'b111 on the word where fill_cnt==LINE_WORDS-1;
  - after the last ack: cyc/stb drop, valid=1 (unless a flush is pending), tag latched, wbs_ack_o pulses next cycle with the requested word.
- Non-cacheable read, or any write -> PASS:
  - single classic cycle (cti=3'b000) with the captured adr/dat/sel/we;
  - on wbm_ack_i, the master drops and wbs_ack_o pulses the following cycle with the captured wbm_dat_i.
  - A write whose tag matches a valid line clears valid when the write completes. There is no write-through update of the line.
- wbm_err_i:
  - in FILL: abort the burst (cyc low next edge), valid=0, fill_cnt=0, wbs_err_o pulses 1 cycle instead of ack;
  - in PASS: wbs_err_o pulses 1 cycle.
- flush_i:
  - in IDLE/HIT_ACK, valid=0 on the next edge;
  - during FILL, flush_pend is set; the burst completes and the requested word is returned, but valid stays 0.
  - Flush has priority over valid-setting when both occur on the same edge.
- CPU drops wbs_cyc_i mid-FILL/PASS: the master transaction completes (fill still marks the line valid), and the slave ack/err is suppressed.
- The fill counter wraps to 0 on completion. A wrapped (non-linear) burst is never issued.
- No new slave request is accepted outside IDLE.

Decomposition:
- Shared package wb_common_params, which must hold:
  - CTI_CLASSIC=3'b000, CTI_INC_BURST=3'b010, CTI_END_OF_BURST=3'b111;
  - BTE_LINEAR=2'b00;
  - state encoding IDLE, HIT_ACK, FILL, PASS.
- Sub-module wb_prefetch_line: LINE_WORDS×32 register array with one write port (index, data, we) and an asynchronous read mux.

Test Plan:
- Cold read 0x0000_0104 (LINE_WORDS=4), slave returns 0xA0..0xA3 -> burst at 0x100..0x10C, cti 010,010,010,111, bte 00; wbs_dat_o=0xA1.
- Then read 0x0000_0108 -> wbs_ack_o exactly 1 cycle after accept, data 0xA2, wbm_cyc_o stays 0.
- Write 0x0000_0100 data 0x55, sel 4'hF -> classic cycle (cti 000), valid cleared. Next read 0x100 re-fills the line.
- Read 0x2000_0000 (outside region) -> single classic read, no burst, line untouched.
- wbm_err_i on the 3rd fill beat -> cyc drops next edge, wbs_err_o 1-cycle pulse, no ack. Re-read of the same line refetches it.
- flush_i during FILL -> requested word returned. The next read of the same line misses and refills; wb_rst_i mid-burst -> all outputs 0 on the next edge.
